ssp_tx_shifter: RTL and testbench
=================================

SSP_TX_SHIFTER -- requirements
Module: ssp_tx_shifter

Interface
REQ-001 The block SHALL have the following ports, one per line: name, direction, width, meaning.
REQ-002 pclk  input  1  single clock; every register updates on its rising edge.
REQ-003 clear  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  transmit enable, active high.
REQ-005 nempty  input  1  TX FIFO not-empty flag; high means wordIn is valid.
REQ-006 wordIn  input  8  word at the TX FIFO head.
REQ-007 rd  output  1  one-cycle pop strobe to the TX FIFO.
REQ-008 ssptxd  output  1  serial transmit data, MSB first.
REQ-009 sspfssout  output  1  frame sync, high for one serial period before bit 7.
REQ-010 sspclkout  output  1  serial clock, pclk/2.
REQ-011 sspoe_b  output  1  serial data output enable, active low.
REQ-012 busy  output  1  high while a frame is in progress (SYNC or SHIFT).

Function
REQ-013 Phase register ph SHALL toggle every pclk cycle; sspclkout SHALL equal ph.
REQ-014 A tick SHALL occur on any pclk edge where ph==1; all state, bit-counter and serial-output changes SHALL occur only on tick edges.
REQ-015 The FSM SHALL have exactly three states: IDLE, SYNC and SHIFT.
REQ-016 IDLE -> SYNC on a tick with en=1 and nempty=1:
- wordIn is captured into an 8-bit shift register;
- sspfssout is set to 1 and ssptxd to 0;
- rd is high for the single following pclk cycle.
REQ-017 In IDLE with en=0 or nempty=0, the block SHALL hold IDLE, and rd SHALL stay 0.
REQ-018 SYNC -> SHIFT on the next tick:
- sspfssout is set to 0;
- ssptxd is set to shift-register bit 7;
- sspoe_b is set to 0;
- the 3-bit bit counter is set to 7.
REQ-019 In SHIFT, each tick SHALL shift the register left by 1, drive the new bit 7 on ssptxd, and decrement the counter.
REQ-020 On the tick where the counter is 0 (bit 0 has been held for one full serial period):
- if en=1 and nempty=1: the next word is loaded exactly as in REQ-016 and the FSM goes to SYNC (back-to-back, no idle gap);
- otherwise: the FSM goes to IDLE, ssptxd=0, and sspoe_b=1.
REQ-021 Frame length SHALL be 18 pclk cycles: 2 for SYNC plus 16 for the 8 bits.
REQ-022 rd SHALL never be high for two consecutive cycles and SHALL never be asserted while nempty=0.
REQ-023 Deasserting en mid-frame SHALL NOT abort the frame; it only blocks the next load.
REQ-024 busy SHALL be 1 in SYNC and SHIFT and 0 in IDLE.

Reset
REQ-025 When clear=1 at a pclk edge, the block SHALL set the following, regardless of state:
- FSM=IDLE, ph=0, counter=0, shift register=0;
- rd=0, ssptxd=0, sspfssout=0, sspclkout=0, sspoe_b=1, busy=0.
REQ-026 A clear during SYNC or SHIFT SHALL abort the frame with no further rd pulse; the aborted word is lost and is not retransmitted.
REQ-027 After clear falls, the first tick SHALL occur on the second pclk edge.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Single word: FIFO holds 0x63, en=1 -> one rd pulse; sspfssout high for 2 cycles; ssptxd sampled on rising sspclkout = 0,1,1,0,0,0,1,1; then IDLE with sspoe_b=1.
- Back-to-back: FIFO holds 0x61 then 0x74 -> two rd pulses 18 cycles apart; the second sspfssout pulse immediately follows bit 0 of 0x61; bits 01100001 then 01110100.
- Empty FIFO: nempty=0, en=1 for 40 cycles -> rd, sspfssout and busy all stay 0; sspoe_b stays 1; sspclkout keeps toggling.
- en dropped mid-frame: en=0 during bit 4 of 0x73 with the FIFO still non-empty -> all 8 bits of 0x73 are sent, then IDLE with no rd.
- clear mid-frame: clear=1 during bit 3 of 0x62 -> all outputs take their reset values on the next edge; no rd; a restart with 0x69 transmits correctly.
- Back-to-back without gaps: four words, 0x62, 0x69, 0x72, 0x64, queued -> exactly 4 rd pulses and 72 cycles of continuous busy.

Source files
------------

// File: rtl/ssp_tx_shifter_if.sv
// Interface bundle for the SSP transmit shifter: TX FIFO handshake plus serial outputs.
interface ssp_tx_shifter_if;
  logic       en;
  logic       nempty;
  logic [7:0] wordIn;
  logic       rd;
  logic       ssptxd;
  logic       sspfssout;
  logic       sspclkout;
  logic       sspoe_b;
  logic       busy;

  modport master (
    output en, nempty, wordIn,
    input  rd, ssptxd, sspfssout, sspclkout, sspoe_b, busy
  );

  modport slave (
    input  en, nempty, wordIn,
    output rd, ssptxd, sspfssout, sspclkout, sspoe_b, busy
  );
endinterface

// File: rtl/ssp_tx_shifter.sv
// SSP transmit shifter: pops words from a TX FIFO and sends them MSB first
// with a one-period frame sync, serial clock at pclk/2.
module ssp_tx_shifter (
  input  logic              pclk,
  input  logic              clear,
  ssp_tx_shifter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SYNC, SHIFT} state_e;

  state_e     state_q, state_d;
  logic       ph_q, ph_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic       rd_q, rd_d;
  logic       txd_q, txd_d;
  logic       fss_q, fss_d;
  logic       oe_b_q, oe_b_d;
  logic       tick;
  logic       load_ok;
  logic       load;

  assign tick    = ph_q;
  assign load_ok = bus.en & bus.nempty;

  always_comb begin
    state_d = state_q;
    ph_d    = ~ph_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    rd_d    = 1'b0;
    txd_d   = txd_q;
    fss_d   = fss_q;
    oe_b_d  = oe_b_q;
    load    = 1'b0;

    if (tick) begin
      case (state_q)
        IDLE: load = load_ok;
        SYNC: begin
          state_d = SHIFT;
          fss_d   = 1'b0;
          txd_d   = sr_q[7];
          oe_b_d  = 1'b0;
          cnt_d   = 3'd7;
        end
        SHIFT: begin
          if (cnt_q == 3'd0) begin
            // bit 0 has had its full period: chain the next word or release the line
            if (load_ok) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b0;
              oe_b_d  = 1'b1;
            end
          end else begin
            sr_d  = {sr_q[6:0], 1'b0};
            txd_d = sr_q[6];
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      state_d = SYNC;
      sr_d    = bus.wordIn;
      fss_d   = 1'b1;
      txd_d   = 1'b0;
      rd_d    = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (clear) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      rd_q    <= 1'b0;
      txd_q   <= 1'b0;
      fss_q   <= 1'b0;
      oe_b_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rd_q    <= rd_d;
      txd_q   <= txd_d;
      fss_q   <= fss_d;
      oe_b_q  <= oe_b_d;
    end
  end

  assign bus.rd        = rd_q;
  assign bus.ssptxd    = txd_q;
  assign bus.sspfssout = fss_q;
  assign bus.sspclkout = ph_q;
  assign bus.sspoe_b   = oe_b_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ssp_tx_shifter.sv
// Bench for ssp_tx_shifter: queue-based FIFO model, frame scoreboard fed on
// every FIFO pop, monitor deserialising the line and checking timing rules.
module tb_ssp_tx_shifter;

  logic pclk;
  logic clear;
  ssp_tx_shifter_if bus ();

  ssp_tx_shifter dut (
    .pclk  (pclk),
    .clear (clear),
    .bus   (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic [7:0] fifo[$];
  logic [7:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int rd_cnt    = 0;
  int cyc_n     = 0;
  int last_rd_cyc = 0;
  int last_rd_gap = 0;
  int run       = 0;
  int last_run  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One cycle of the FIFO model: a pop on rd moves the head word into the scoreboard
  task automatic cyc();
    @(negedge pclk);
    if (bus.rd === 1'b1) begin
      rd_cnt++;
      if (fifo.size() != 0) exp_q.push_back(fifo.pop_front());
    end
    bus.nempty = (fifo.size() != 0);
    bus.wordIn = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic wait_rd(input int budget);
    int start;
    start = rd_cnt;
    for (int i = 0; i < budget && rd_cnt == start; i++) cyc();
    check("rd_within_budget", rd_cnt, start + 1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && bus.busy === 1'b1; i++) cyc();
    check("idle_within_budget", bus.busy, 1'b0);
  endtask

  // Monitor: samples 1 time unit after each rising pclk
  logic       armed = 1'b0;
  int         nbits = 0;
  int         fss_len = 0;
  logic [7:0] shreg = '0;
  logic       prev_sck = 1'b0;
  logic       prev_rd = 1'b0;

  always @(posedge pclk) begin
    #1;
    cyc_n++;
    if (clear) begin
      check("reset_outputs",
            {bus.rd, bus.ssptxd, bus.sspfssout, bus.sspclkout, bus.sspoe_b, bus.busy},
            6'b000010);
      armed = 1'b0; nbits = 0; fss_len = 0; run = 0; prev_sck = 1'b0; prev_rd = 1'b0;
    end else begin
      if (bus.rd) begin
        check("rd_not_consecutive", prev_rd, 1'b0);
        check("rd_only_when_nempty", bus.nempty, 1'b1);
        last_rd_gap = cyc_n - last_rd_cyc;
        last_rd_cyc = cyc_n;
      end
      prev_rd = bus.rd;

      if (bus.busy) run++;
      else if (run != 0) begin last_run = run; run = 0; end

      if (bus.sspfssout) begin
        fss_len++; armed = 1'b1; nbits = 0; shreg = '0;
      end else begin
        if (fss_len != 0) begin
          check("fss_length", fss_len, 2);
          fss_len = 0;
        end
        if (armed && bus.sspclkout && !prev_sck) begin
          check("oe_during_data", bus.sspoe_b, 1'b0);
          shreg = {shreg[6:0], bus.ssptxd};
          nbits++;
          if (nbits == 8) begin
            check("frame_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("frame_data", shreg, exp_q.pop_front());
            armed = 1'b0;
          end
        end
      end
      prev_sck = bus.sspclkout;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, bad, toggles;
    logic psck;
    clear = 1'b1;
    bus.en = 1'b0; bus.nempty = 1'b0; bus.wordIn = 8'h00;
    repeat (4) cyc();
    clear = 1'b0;
    repeat (3) cyc();

    // single word
    rd0 = rd_cnt;
    fifo.push_back(8'h63); bus.en = 1'b1;
    wait_rd(20);
    wait_idle(40);
    repeat (4) cyc();
    check("single_rd_count", rd_cnt - rd0, 1);
    check("single_busy_len", last_run, 18);
    check("single_oe_idle", bus.sspoe_b, 1'b1);
    check("single_all_checked", exp_q.size(), 0);

    // back-to-back pair
    rd0 = rd_cnt;
    fifo.push_back(8'h61); fifo.push_back(8'h74);
    wait_rd(20);
    wait_idle(80);
    repeat (4) cyc();
    check("b2b_rd_count", rd_cnt - rd0, 2);
    check("b2b_rd_gap", last_rd_gap, 18);
    check("b2b_busy_len", last_run, 36);

    // empty FIFO with enable high
    bad = 0; toggles = 0; psck = bus.sspclkout;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.rd || bus.sspfssout || bus.busy || !bus.sspoe_b) bad++;
      if (bus.sspclkout != psck) toggles++;
      psck = bus.sspclkout;
    end
    check("empty_quiet", bad, 0);
    check("empty_sck_toggles", toggles, 40);

    // en dropped during bit 4, FIFO still holds another word
    rd0 = rd_cnt;
    fifo.push_back(8'h73); fifo.push_back(8'h99);
    wait_rd(20);
    repeat (8) cyc();
    bus.en = 1'b0;
    wait_idle(40);
    repeat (10) cyc();
    check("endrop_rd_count", rd_cnt - rd0, 1);
    check("endrop_fifo_left", fifo.size(), 1);
    check("endrop_busy_len", last_run, 18);
    check("endrop_oe_idle", bus.sspoe_b, 1'b1);
    fifo.delete();
    cyc();

    // clear during bit 3, then restart
    rd0 = rd_cnt;
    fifo.push_back(8'h62); bus.en = 1'b1;
    wait_rd(20);
    repeat (10) cyc();
    clear = 1'b1;
    cyc();
    exp_q.delete();
    fifo.push_back(8'h69);
    cyc();
    check("clear_no_rd", rd_cnt - rd0, 1);
    rd0 = rd_cnt;
    clear = 1'b0;
    cyc();
    check("restart_no_early_tick", bus.rd, 1'b0);
    cyc();
    check("restart_tick_second_edge", bus.rd, 1'b1);
    wait_idle(40);
    repeat (4) cyc();
    check("restart_rd_count", rd_cnt - rd0, 1);
    check("restart_all_checked", exp_q.size(), 0);

    // four words back-to-back
    rd0 = rd_cnt;
    fifo.push_back(8'h62); fifo.push_back(8'h69);
    fifo.push_back(8'h72); fifo.push_back(8'h64);
    wait_rd(20);
    wait_idle(120);
    repeat (4) cyc();
    check("four_rd_count", rd_cnt - rd0, 4);
    check("four_busy_len", last_run, 72);

    // randomized traffic with enable flips
    for (int it = 0; it < 40; it++) begin
      int n;
      int cycles;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) fifo.push_back(8'($urandom_range(0, 255)));
      cycles = $urandom_range(4, 50);
      for (int c = 0; c < cycles; c++) begin
        if ($urandom_range(0, 7) == 0) bus.en = ~bus.en;
        cyc();
      end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 3000 && (fifo.size() != 0 || bus.busy === 1'b1); i++) cyc();
    repeat (4) cyc();
    check("random_fifo_drained", fifo.size(), 0);
    check("random_all_checked", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
